reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_scoreboard.sv | 43 ++++
 rtl/reg_file_sb.sv | 100 ++++++++++
 tb/tb_reg_file_sb.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the scoreboarded register file: default widths,
// depth helper and write-port priority.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_RD_DEF = 2;

  typedef enum logic {
    PRIO_WR0 = 1'b0,
    PRIO_WR1 = 1'b1
  } wr_prio_e;

  // The load port wins a same-address collision with the ALU port.
  localparam wr_prio_e WR_PRIO = PRIO_WR1;

  function automatic int unsigned rf_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, issue beats a
// same-cycle writeback; register 0 is never busy.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        wr0_en_in,
  input  logic [ADDR_W-1:0]           wr0_addr_in,
  input  logic                        wr1_en_in,
  input  logic [ADDR_W-1:0]           wr1_addr_in,
  input  logic                        issue_en_in,
  input  logic [ADDR_W-1:0]           issue_rd_in,
  output logic [rf_depth(ADDR_W)-1:0] busy_vec_out
);

  localparam int unsigned DEPTH = rf_depth(ADDR_W);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // NOTE: busy_d gets its full default first so no path leaves it unassigned;
  // otherwise synthesis infers a latch.
  always_comb begin
    busy_d = busy_q;
    if (wr0_en_in && (wr0_addr_in != '0)) busy_d[wr0_addr_in] = 1'b0;
    if (wr1_en_in && (wr1_addr_in != '0)) busy_d[wr1_addr_in] = 1'b0;
    if (issue_en_in && (issue_rd_in != '0)) busy_d[issue_rd_in] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: blocking '=' above builds combinational next-state; the register
  // below uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec_out = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read, dual-write register file with issue scoreboard and registered
// reads. Define REG_FILE_BYPASS_EN for write-first read bypass.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_RD*ADDR_W-1:0]    rs_addr_in,
  output logic [NUM_RD*DATA_W-1:0]    rs_data_out,
  output logic [NUM_RD-1:0]           rs_busy_out,
  input  logic                        wr0_en_in,
  input  logic [ADDR_W-1:0]           wr0_addr_in,
  input  logic [DATA_W-1:0]           wr0_data_in,
  input  logic                        wr1_en_in,
  input  logic [ADDR_W-1:0]           wr1_addr_in,
  input  logic [DATA_W-1:0]           wr1_data_in,
  input  logic                        issue_en_in,
  input  logic [ADDR_W-1:0]           issue_rd_in,
  output logic [rf_depth(ADDR_W)-1:0] busy_vec_out
);

  localparam int unsigned DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_next [NUM_RD];
  logic              wr0_act;
  logic              wr1_act;
  logic              wr_same;
  logic              wr0_eff;
  logic              wr1_eff;

  assign wr0_act = wr0_en_in && (wr0_addr_in != '0);
  assign wr1_act = wr1_en_in && (wr1_addr_in != '0);
  assign wr_same = wr0_act && wr1_act && (wr0_addr_in == wr1_addr_in);
  assign wr0_eff = wr0_act && !(wr_same && (WR_PRIO == PRIO_WR1));
  assign wr1_eff = wr1_act && !(wr_same && (WR_PRIO == PRIO_WR0));

  // NOTE: the array is reset because the register file must come up all-zero;
  // this forces flops rather than a RAM macro.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (wr0_eff) mem[wr0_addr_in] <= wr0_data_in;
      if (wr1_eff) mem[wr1_addr_in] <= wr1_data_in;
    end
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rs_addr_in[k*ADDR_W +: ADDR_W];

`ifdef REG_FILE_BYPASS_EN
    logic hit0;
    logic hit1;
    assign hit0 = wr0_eff && (wr0_addr_in == addr);
    assign hit1 = wr1_eff && (wr1_addr_in == addr);

    always_comb begin
      if (addr == '0) rd_next[k] = '0;
      else if (hit1)  rd_next[k] = wr1_data_in;
      else if (hit0)  rd_next[k] = wr0_data_in;
      else            rd_next[k] = mem[addr];
    end

    // A register being written back this edge is already usable.
    assign rs_busy_out[k] = (addr != '0) && busy_vec_out[addr] && !hit0 && !hit1;
`else
    assign rd_next[k]     = (addr == '0) ? '0 : mem[addr];
    assign rs_busy_out[k] = (addr != '0) && busy_vec_out[addr];
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rs_data_out <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_RD); k++) rs_data_out[k*DATA_W +: DATA_W] <= rd_next[k];
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .wr0_en_in    (wr0_en_in),
    .wr0_addr_in  (wr0_addr_in),
    .wr1_en_in    (wr1_en_in),
    .wr1_addr_in  (wr1_addr_in),
    .issue_en_in  (issue_en_in),
    .issue_rd_in  (issue_rd_in),
    .busy_vec_out (busy_vec_out)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: reference model plus read-data
// scoreboard queue, directed steps followed by a random burst.
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic             clk_in;
  logic             rst_in;
  logic [NR*AW-1:0] rs_addr_in;
  logic [NR*DW-1:0] rs_data_out;
  logic [NR-1:0]    rs_busy_out;
  logic             wr0_en_in;
  logic [AW-1:0]    wr0_addr_in;
  logic [DW-1:0]    wr0_data_in;
  logic             wr1_en_in;
  logic [AW-1:0]    wr1_addr_in;
  logic [DW-1:0]    wr1_data_in;
  logic             issue_en_in;
  logic [AW-1:0]    issue_rd_in;
  logic [DEPTH-1:0] busy_vec_out;

  reg_file_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rs_addr_in   (rs_addr_in),
    .rs_data_out  (rs_data_out),
    .rs_busy_out  (rs_busy_out),
    .wr0_en_in    (wr0_en_in),
    .wr0_addr_in  (wr0_addr_in),
    .wr0_data_in  (wr0_data_in),
    .wr1_en_in    (wr1_en_in),
    .wr1_addr_in  (wr1_addr_in),
    .wr1_data_in  (wr1_data_in),
    .issue_en_in  (issue_en_in),
    .issue_rd_in  (issue_rd_in),
    .busy_vec_out (busy_vec_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] exp;
  } rd_exp_t;

  rd_exp_t          sbq[$];
  logic [DW-1:0]    mdl_mem [DEPTH];
  logic [DEPTH-1:0] mdl_busy;
  int               n_checks = 0;
  int               n_errors = 0;

`ifdef REG_FILE_BYPASS_EN
  localparam logic [DW-1:0] COLLIDE_EXP = 32'h0000_A5A5;
`else
  localparam logic [DW-1:0] COLLIDE_EXP = 32'h0000_1111;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (rst_in || a == '0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (wr1_en_in && wr1_addr_in == a) return wr1_data_in;
    if (wr0_en_in && wr0_addr_in == a) return wr0_data_in;
`endif
    return mdl_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if ((wr0_en_in && wr0_addr_in == a) || (wr1_en_in && wr1_addr_in == a)) return 1'b0;
`endif
    return mdl_busy[a];
  endfunction

  task automatic idle();
    wr0_en_in   = 1'b0;
    wr0_addr_in = '0;
    wr0_data_in = '0;
    wr1_en_in   = 1'b0;
    wr1_addr_in = '0;
    wr1_data_in = '0;
    issue_en_in = 1'b0;
    issue_rd_in = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rs_addr_in = {a1, a0};
  endtask

  // One clock: check comb busy, push read expectations, advance model, pop/compare.
  task automatic step(input string tag);
    logic [AW-1:0] a;
    rd_exp_t       e;
    #1;
    for (int k = 0; k < NR; k++) begin
      a = rs_addr_in[k*AW +: AW];
      check($sformatf("%s/rs_busy%0d", tag, k), 64'(rs_busy_out[k]), 64'(exp_busy(a)));
      sbq.push_back('{tag, k, exp_read(a)});
    end
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
      mdl_busy = '0;
    end else begin
      if (wr0_en_in && wr0_addr_in != '0) mdl_mem[wr0_addr_in] = wr0_data_in;
      if (wr1_en_in && wr1_addr_in != '0) mdl_mem[wr1_addr_in] = wr1_data_in;
      if (wr0_en_in) mdl_busy[wr0_addr_in] = 1'b0;
      if (wr1_en_in) mdl_busy[wr1_addr_in] = 1'b0;
      if (issue_en_in) mdl_busy[issue_rd_in] = 1'b1;
      mdl_busy[0] = 1'b0;
    end
    @(posedge clk_in);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (sbq.size() == 0) begin
        check($sformatf("%s/sbq_empty", tag), 64'(1), 64'(0));
      end else begin
        e = sbq.pop_front();
        check($sformatf("%s/rd%0d", e.tag, e.port), 64'(rs_data_out[e.port*DW +: DW]), 64'(e.exp));
      end
    end
    check($sformatf("%s/busy_vec", tag), 64'(busy_vec_out), 64'(mdl_busy));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 'x;
    mdl_busy = 'x;
    idle();
    set_rd(5'd0, 5'd0);

    // Reset overrides a simultaneous write and issue.
    rst_in      = 1'b1;
    wr0_en_in   = 1'b1;
    wr0_addr_in = 5'd4;
    wr0_data_in = 32'h0000_1234;
    issue_en_in = 1'b1;
    issue_rd_in = 5'd4;
    step("reset_override");
    step("reset_hold");
    rst_in = 1'b0;
    idle();

    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), AW'(DEPTH - 1 - a));
      step("reset_read");
    end

    wr0_en_in   = 1'b1;
    wr0_addr_in = 5'd5;
    wr0_data_in = 32'hDEAD_BEEF;
    set_rd(5'd0, 5'd0);
    step("wr0_addr5");
    idle();
    set_rd(5'd5, 5'd5);
    step("rd_addr5");
    check("rd_addr5_const", 64'(rs_data_out[DW-1:0]), 64'(32'hDEAD_BEEF));

    wr0_en_in   = 1'b1;
    wr0_addr_in = 5'd7;
    wr0_data_in = 32'h11;
    wr1_en_in   = 1'b1;
    wr1_addr_in = 5'd7;
    wr1_data_in = 32'h22;
    set_rd(5'd0, 5'd0);
    step("wr_both7");
    idle();
    set_rd(5'd7, 5'd7);
    step("rd_addr7");
    check("rd_addr7_const", 64'(rs_data_out[2*DW-1:DW]), 64'(32'h22));

    wr0_en_in   = 1'b1;
    wr0_addr_in = 5'd0;
    wr0_data_in = 32'hFFFF_FFFF;
    issue_en_in = 1'b1;
    issue_rd_in = 5'd0;
    step("wr_issue_r0");
    idle();
    set_rd(5'd0, 5'd0);
    step("rd_r0");
    check("r0_const", 64'(rs_data_out), 64'(0));
    check("r0_busy_const", 64'(busy_vec_out[0]), 64'(0));

    issue_en_in = 1'b1;
    issue_rd_in = 5'd3;
    step("issue3");
    idle();
    set_rd(5'd3, 5'd0);
    step("busy3");
    wr1_en_in   = 1'b1;
    wr1_addr_in = 5'd3;
    wr1_data_in = 32'h33;
    step("wr1_clear3");
    idle();
    step("after_clear3");
    check("clear3_const", 64'(rs_busy_out[0]), 64'(0));
    issue_en_in = 1'b1;
    issue_rd_in = 5'd3;
    wr0_en_in   = 1'b1;
    wr0_addr_in = 5'd3;
    wr0_data_in = 32'h44;
    step("issue_vs_wr3");
    idle();
    step("busy3_kept");
    check("kept3_const", 64'(busy_vec_out[3]), 64'(1));
    wr1_en_in   = 1'b1;
    wr1_addr_in = 5'd3;
    wr1_data_in = 32'h55;
    step("wr1_clear3_again");
    idle();

    wr0_en_in   = 1'b1;
    wr0_addr_in = 5'd9;
    wr0_data_in = 32'h1111;
    set_rd(5'd0, 5'd0);
    step("wr9_old");
    wr0_data_in = 32'hA5A5;
    set_rd(5'd9, 5'd9);
    step("collide9");
    check("collide9_const", 64'(rs_data_out[DW-1:0]), 64'(COLLIDE_EXP));
    idle();
    step("after_collide9");
    check("after_collide9_const", 64'(rs_data_out[DW-1:0]), 64'(32'hA5A5));

    for (int n = 0; n < 300; n++) begin
      wr0_en_in   = 1'($urandom_range(0, 1));
      wr0_addr_in = AW'($urandom_range(0, DEPTH - 1));
      wr0_data_in = $urandom;
      wr1_en_in   = 1'($urandom_range(0, 1));
      wr1_addr_in = ($urandom_range(0, 3) == 0) ? wr0_addr_in : AW'($urandom_range(0, DEPTH - 1));
      wr1_data_in = $urandom;
      issue_en_in = 1'($urandom_range(0, 1));
      issue_rd_in = ($urandom_range(0, 3) == 0) ? wr0_addr_in : AW'($urandom_range(0, DEPTH - 1));
      set_rd(AW'($urandom_range(0, DEPTH - 1)),
             ($urandom_range(0, 3) == 0) ? wr1_addr_in : AW'($urandom_range(0, DEPTH - 1)));
      step("random");
    end

    // First cycle after reset release takes a write and an issue normally.
    idle();
    rst_in = 1'b1;
    step("reset2");
    rst_in      = 1'b0;
    wr0_en_in   = 1'b1;
    wr0_addr_in = 5'd2;
    wr0_data_in = 32'h0000_BEEF;
    issue_en_in = 1'b1;
    issue_rd_in = 5'd6;
    set_rd(5'd0, 5'd0);
    step("post_reset");
    idle();
    set_rd(5'd2, 5'd6);
    step("post_reset_rd");
    check("post_reset_data_const", 64'(rs_data_out[DW-1:0]), 64'(32'h0000_BEEF));
    check("post_reset_busy_const", 64'(rs_busy_out), 64'(2'b10));

    check("sbq_drained", 64'(sbq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
